// File: rtl/amo_sequencer.sv
// RV32A sequencer for LR.W / SC.W / AMO*.W on the shared data-memory port.
// Stalls the pipeline around a read-modify-write and owns the single LR/SC
// reservation register.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for amoValid_i; decodes misaligned / SC outcome
// ST_READ  | read strobe out, memRData_i returns next cycle
// ST_CALC  | old value latched, new value computed (LR sets reservation)
// ST_WRITE | full-word write out; committed, flush no longer aborts
// ST_DONE  | done_o pulse, pipeline advances on the closing edge
module amo_sequencer #(
   parameter int RES_GRANULE_LSB = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        amoValid_i,
   input  logic [4:0]  amoFunct5_i,
   input  logic [31:0] amoAddr_i,
   input  logic [31:0] amoRs2_i,
   input  logic        flush_i,
   input  logic        snoopWr_i,
   input  logic [31:0] snoopAddr_i,
   output logic        stall_o,
   output logic        done_o,
   output logic        misaligned_o,
   output logic [31:0] result_o,
   output logic        memRStrobe_o,
   output logic [31:0] memAddr_o,
   input  logic [31:0] memRData_i,
   output logic [31:0] memWData_o,
   output logic [3:0]  memWMask_o
);

   localparam int RW = 32 - RES_GRANULE_LSB;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CALC, ST_WRITE, ST_DONE} state_t;

   state_t        state;
   logic [4:0]    funct_q;
   logic [31:0]   addr_q;
   logic [31:0]   rs2_q;
   logic          res_valid;
   logic [RW-1:0] res_addr;
   logic [31:0]   amo_new;
   logic          op_ok;
   logic          snoop_hit;
   logic          sc_match;
   logic          lsb_unused;

   // Byte-offset bits below the reservation granule never take part in a match.
   assign lsb_unused = ^snoopAddr_i[RES_GRANULE_LSB-1:0] ^ ^addr_q[1:0];

   assign snoop_hit = snoopWr_i && (snoopAddr_i[31:RES_GRANULE_LSB] == res_addr);
   assign sc_match  = res_valid && (amoAddr_i[31:RES_GRANULE_LSB] == res_addr);

   // Pipeline hold: only the IDLE term is combinational so the first cycle stalls.
   assign stall_o = ((state == ST_IDLE) && amoValid_i && !flush_i) ||
                    (state == ST_READ) || (state == ST_CALC) || (state == ST_WRITE);

   // New memory value from the returned old word; op_ok low means no write.
   always_comb begin
      amo_new = rs2_q;
      op_ok   = 1'b1;
      case (funct_q)
         F_SWAP:  amo_new = rs2_q;
         F_ADD:   amo_new = memRData_i + rs2_q;
         F_XOR:   amo_new = memRData_i ^ rs2_q;
         F_AND:   amo_new = memRData_i & rs2_q;
         F_OR:    amo_new = memRData_i | rs2_q;
         F_MIN:   amo_new = ($signed(memRData_i) < $signed(rs2_q)) ? memRData_i : rs2_q;
         F_MAX:   amo_new = ($signed(memRData_i) > $signed(rs2_q)) ? memRData_i : rs2_q;
         F_MINU:  amo_new = (memRData_i < rs2_q) ? memRData_i : rs2_q;
         F_MAXU:  amo_new = (memRData_i > rs2_q) ? memRData_i : rs2_q;
         default: op_ok   = 1'b0;
      endcase
   end

   // Sequencer FSM, reservation tracking and registered memory/result outputs.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state        <= ST_IDLE;
         funct_q      <= '0;
         addr_q       <= '0;
         rs2_q        <= '0;
         res_valid    <= 1'b0;
         res_addr     <= '0;
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         result_o     <= '0;
         memRStrobe_o <= 1'b0;
         memAddr_o    <= '0;
         memWData_o   <= '0;
         memWMask_o   <= 4'b0000;
      end else begin
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         memRStrobe_o <= 1'b0;
         memAddr_o    <= '0;
         memWData_o   <= '0;
         memWMask_o   <= 4'b0000;
         if (snoop_hit)
            res_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (flush_i) begin
                  res_valid <= 1'b0;
               end else if (amoValid_i) begin
                  funct_q <= amoFunct5_i;
                  addr_q  <= amoAddr_i;
                  rs2_q   <= amoRs2_i;
                  if (amoAddr_i[1:0] != 2'b00) begin
                     res_valid    <= 1'b0;
                     result_o     <= '0;
                     done_o       <= 1'b1;
                     misaligned_o <= 1'b1;
                     state        <= ST_DONE;
                  end else if (amoFunct5_i == F_SC) begin
                     res_valid <= 1'b0;
                     if (sc_match) begin
                        result_o   <= 32'd0;
                        memAddr_o  <= {amoAddr_i[31:2], 2'b00};
                        memWData_o <= amoRs2_i;
                        memWMask_o <= 4'b1111;
                        state      <= ST_WRITE;
                     end else begin
                        result_o <= 32'd1;
                        done_o   <= 1'b1;
                        state    <= ST_DONE;
                     end
                  end else begin
                     memRStrobe_o <= 1'b1;
                     memAddr_o    <= {amoAddr_i[31:2], 2'b00};
                     state        <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (flush_i) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (flush_i) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  result_o <= memRData_i;
                  if (funct_q == F_LR) begin
                     res_valid <= 1'b1;
                     res_addr  <= addr_q[31:RES_GRANULE_LSB];
                     done_o    <= 1'b1;
                     state     <= ST_DONE;
                  end else if (op_ok) begin
                     memAddr_o  <= {addr_q[31:2], 2'b00};
                     memWData_o <= amo_new;
                     memWMask_o <= 4'b1111;
                     state      <= ST_WRITE;
                  end else begin
                     done_o <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_WRITE: begin
               if (addr_q[31:RES_GRANULE_LSB] == res_addr)
                  res_valid <= 1'b0;
               done_o <= 1'b1;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: a transaction-level model turns each instruction
// into an expected per-cycle trace; one process compares every cycle.
module tb_amo_sequencer;

   localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011;
   localparam logic [4:0] XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100;
   localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        amoValid_i = 1'b0;
   logic [4:0]  amoFunct5_i = '0;
   logic [31:0] amoAddr_i = '0;
   logic [31:0] amoRs2_i = '0;
   logic        flush_i = 1'b0;
   logic        snoopWr_i = 1'b0;
   logic [31:0] snoopAddr_i = '0;
   logic        stall_o, done_o, misaligned_o, memRStrobe_o;
   logic [31:0] result_o, memAddr_o, memWData_o;
   logic [31:0] memRData_i = '0;
   logic [3:0]  memWMask_o;

   amo_sequencer #(.RES_GRANULE_LSB(2)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .amoValid_i(amoValid_i), .amoFunct5_i(amoFunct5_i),
      .amoAddr_i(amoAddr_i), .amoRs2_i(amoRs2_i), .flush_i(flush_i), .snoopWr_i(snoopWr_i),
      .snoopAddr_i(snoopAddr_i), .stall_o(stall_o), .done_o(done_o), .misaligned_o(misaligned_o),
      .result_o(result_o), .memRStrobe_o(memRStrobe_o), .memAddr_o(memAddr_o),
      .memRData_i(memRData_i), .memWData_o(memWData_o), .memWMask_o(memWMask_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit        stall, done, mis, rs;
      bit [3:0]  wm;
      bit [31:0] addr, wdata, res;
      bit        chk_res;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] tb_mem[0:255];
   logic [31:0] model_mem[0:255];
   bit          res_v = 1'b0;
   logic [29:0] res_a = '0;
   logic [31:0] last_result = '0;

   // Memory: read data one cycle after the strobe, full-word writes on mask 1111.
   always @(posedge clk_i) begin
      if (memRStrobe_o) memRData_i <= tb_mem[memAddr_o[9:2]];
      if (memWMask_o == 4'hF) tb_mem[memAddr_o[9:2]] = memWData_o;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t rec(bit st, bit dn, bit ms, bit rs, bit [3:0] wm,
                                bit [31:0] ad, bit [31:0] wd, bit [31:0] rv, bit cr);
      exp_t e;
      e.stall = st; e.done = dn; e.mis = ms; e.rs = rs; e.wm = wm;
      e.addr = ad; e.wdata = wd; e.res = rv; e.chk_res = cr;
      return e;
   endfunction

   function automatic logic [31:0] amo_calc(input logic [4:0] f, input logic [31:0] o,
                                            input logic [31:0] r, output bit ok);
      ok = 1'b1;
      case (f)
         SWAP: return r;
         ADD:  return o + r;
         XOR:  return o ^ r;
         AND:  return o & r;
         OR:   return o | r;
         MIN:  return ($signed(o) < $signed(r)) ? o : r;
         MAX:  return ($signed(o) > $signed(r)) ? o : r;
         MINU: return (o < r) ? o : r;
         MAXU: return (o > r) ? o : r;
         default: begin ok = 1'b0; return o; end
      endcase
   endfunction

   // Per-cycle comparison against the model trace.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_o", stall_o, e.stall);
            chk("done_o", done_o, e.done);
            chk("misaligned_o", misaligned_o, e.mis);
            chk("memRStrobe_o", memRStrobe_o, e.rs);
            chk("memWMask_o", memWMask_o, e.wm);
            if (e.rs || e.wm != 0) chk("memAddr_o", memAddr_o, e.addr);
            if (e.wm != 0) chk("memWData_o", memWData_o, e.wdata);
            if (e.done && e.chk_res) chk("result_o", result_o, e.res);
            if (done_o) last_result = result_o;
         end
      end
   end

   task automatic setmem(input logic [31:0] a, input logic [31:0] d);
      tb_mem[a[9:2]] = d;
      model_mem[a[9:2]] = d;
   endtask

   task automatic idle_cycle(input bit sw, input logic [31:0] sa);
      @(posedge clk_i); #1;
      amoValid_i = 1'b0; flush_i = 1'b0; snoopWr_i = sw; snoopAddr_i = sa;
      exp_q.push_back(rec(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      if (sw && res_v && sa[31:2] == res_a) res_v = 1'b0;
   endtask

   // Builds the expected trace of one instruction from the ISA rules, then drives it.
   task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] r,
                         input int flush_at = -1, input int rst_at = -1,
                         input int snp_at = -1, input logic [31:0] snp_a = 0);
      exp_t        tr[$];
      logic [31:0] wa, old, nv;
      bit          ok, do_wr;
      wa = {a[31:2], 2'b00};
      old = model_mem[a[9:2]];
      do_wr = 1'b0;
      nv = '0;
      tr.push_back(rec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      if (a[1:0] != 2'b00) begin
         tr.push_back(rec(0, 1, 1, 0, 4'h0, 0, 0, 0, 0));
         res_v = 1'b0;
      end else if (f == SC) begin
         if (res_v && res_a == a[31:2]) begin
            tr.push_back(rec(1, 0, 0, 0, 4'hF, wa, r, 0, 0));
            tr.push_back(rec(0, 1, 0, 0, 4'h0, 0, 0, 32'd0, 1));
            do_wr = 1'b1; nv = r;
         end else begin
            tr.push_back(rec(0, 1, 0, 0, 4'h0, 0, 0, 32'd1, 1));
         end
         res_v = 1'b0;
      end else begin
         tr.push_back(rec(1, 0, 0, 1, 4'h0, wa, 0, 0, 0));
         tr.push_back(rec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0));
         if (flush_at == 1 || flush_at == 2) begin
            while (tr.size() > flush_at + 1) void'(tr.pop_back());
            res_v = 1'b0;
         end else begin
            if (snp_at >= 0 && res_v && snp_a[31:2] == res_a) res_v = 1'b0;
            if (f == LR) begin
               tr.push_back(rec(0, 1, 0, 0, 4'h0, 0, 0, old, 1));
               res_v = 1'b1; res_a = a[31:2];
            end else begin
               nv = amo_calc(f, old, r, ok);
               if (ok) begin
                  tr.push_back(rec(1, 0, 0, 0, 4'hF, wa, nv, 0, 0));
                  do_wr = 1'b1;
                  if (res_a == a[31:2]) res_v = 1'b0;
               end
               tr.push_back(rec(0, 1, 0, 0, 4'h0, 0, 0, old, 1));
            end
         end
      end
      if (rst_at >= 0) begin
         while (tr.size() > rst_at + 1) void'(tr.pop_back());
         do_wr = 1'b0; res_v = 1'b0; res_a = '0;
      end
      if (do_wr) model_mem[a[9:2]] = nv;
      for (int i = 0; i < tr.size(); i++) begin
         @(posedge clk_i); #1;
         amoValid_i = 1'b1; amoFunct5_i = f; amoAddr_i = a; amoRs2_i = r;
         flush_i = (i == flush_at);
         snoopWr_i = (i == snp_at); snoopAddr_i = snp_a;
         exp_q.push_back(tr[i]);
         if (i == rst_at) begin
            #5;
            amoValid_i = 1'b0;
            reset_i = 1'b0;
            #1;
            chk("rst_wmask", memWMask_o, 4'h0);
            chk("rst_stall", stall_o, 0);
            chk("rst_done", done_o, 0);
            #1 reset_i = 1'b1;
         end
      end
      idle_cycle(1'b0, 32'h0);
   endtask

   typedef struct { logic [4:0] f; logic [31:0] old, rs2, newv; } vec_t;
   vec_t vecs[$];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; model_mem[i] = '0; end
      #12;
      chk("reset_stall", stall_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_mis", misaligned_o, 0);
      chk("reset_result", result_o, 0);
      chk("reset_rstrobe", memRStrobe_o, 0);
      chk("reset_addr", memAddr_o, 0);
      chk("reset_wdata", memWData_o, 0);
      chk("reset_wmask", memWMask_o, 0);
      @(negedge clk_i); reset_i = 1'b1;

      // AMOADD basic timing and values.
      setmem(32'h100, 32'd5);
      run_op(ADD, 32'h100, 32'd3);
      chk("add_mem", tb_mem[8'h40], 32'd8);
      chk("add_result", last_result, 32'd5);

      // Signed vs unsigned max.
      setmem(32'h104, 32'hFFFF_FFFF);
      run_op(MAX, 32'h104, 32'd1);
      chk("max_mem", tb_mem[8'h41], 32'd1);
      chk("max_result", last_result, 32'hFFFF_FFFF);
      setmem(32'h104, 32'hFFFF_FFFF);
      run_op(MAXU, 32'h104, 32'd1);
      chk("maxu_mem", tb_mem[8'h41], 32'hFFFF_FFFF);

      // Remaining operations against hand-computed results.
      vecs.push_back('{MIN,  32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFE});
      vecs.push_back('{MINU, 32'hFFFF_FFFE, 32'd3,       32'd3});
      vecs.push_back('{XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0});
      vecs.push_back('{AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000});
      vecs.push_back('{OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0});
      vecs.push_back('{SWAP, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0001});
      vecs.push_back('{ADD,  32'hFFFF_FFFF, 32'd2,       32'd1});
      foreach (vecs[k]) begin
         setmem(32'h110, vecs[k].old);
         run_op(vecs[k].f, 32'h110, vecs[k].rs2);
         chk("op_mem", tb_mem[8'h44], vecs[k].newv);
      end

      // Undefined funct5: read, no write, old value returned.
      setmem(32'h114, 32'h0000_0777);
      run_op(5'b00101, 32'h114, 32'd9);
      chk("undef_mem", tb_mem[8'h45], 32'h0000_0777);

      // LR then SC succeeds once, second SC fails.
      setmem(32'h200, 32'h11);
      run_op(LR, 32'h200, 32'd0);
      chk("lr_result", last_result, 32'h11);
      run_op(SC, 32'h200, 32'hAB);
      chk("sc_result", last_result, 32'd0);
      chk("sc_mem", tb_mem[8'h80], 32'hAB);
      run_op(SC, 32'h200, 32'hCD);
      chk("sc2_result", last_result, 32'd1);
      chk("sc2_mem", tb_mem[8'h80], 32'hAB);

      // Snoop inside the reserved word kills it; next word does not.
      run_op(LR, 32'h200, 32'd0);
      idle_cycle(1'b1, 32'h202);
      run_op(SC, 32'h200, 32'h55);
      chk("snoop_hit_sc", last_result, 32'd1);
      run_op(LR, 32'h200, 32'd0);
      idle_cycle(1'b1, 32'h204);
      run_op(SC, 32'h200, 32'h66);
      chk("snoop_miss_sc", last_result, 32'd0);
      chk("snoop_miss_mem", tb_mem[8'h80], 32'h66);

      // Snoop to the LR word in the LR's own CALC cycle: LR wins.
      run_op(LR, 32'h200, 32'd0, -1, -1, 2, 32'h200);
      run_op(SC, 32'h200, 32'h77);
      chk("lr_prio_sc", last_result, 32'd0);

      // AMO store to the reserved word clears the reservation.
      run_op(LR, 32'h200, 32'd0);
      run_op(ADD, 32'h200, 32'd1);
      run_op(SC, 32'h200, 32'h99);
      chk("amo_clr_sc", last_result, 32'd1);

      // Flush in CALC aborts, flush in WRITE is ignored.
      setmem(32'h108, 32'h0000_0010);
      run_op(SWAP, 32'h108, 32'h55, 2);
      chk("flush_calc_mem", tb_mem[8'h42], 32'h10);
      run_op(SWAP, 32'h108, 32'h55, 3);
      chk("flush_write_mem", tb_mem[8'h42], 32'h55);

      // Flush in READ also drops the reservation.
      run_op(LR, 32'h200, 32'd0);
      run_op(ADD, 32'h300, 32'd1, 1);
      run_op(SC, 32'h200, 32'h1);
      chk("flush_read_sc", last_result, 32'd1);

      // Misaligned: done+misaligned next cycle, no memory traffic.
      run_op(OR, 32'h102, 32'hF);
      chk("mis_mem", tb_mem[8'h40], 32'd8);

      // Reset during WRITE drops the write and the reservation.
      run_op(LR, 32'h200, 32'd0);
      run_op(ADD, 32'h100, 32'd1, -1, 3);
      chk("rst_write_mem", tb_mem[8'h40], 32'd8);
      run_op(SC, 32'h200, 32'h3);
      chk("rst_res_sc", last_result, 32'd1);

      repeat (3) @(posedge clk_i);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multi-cycle controller that sequences RV32A instructions (LR.W, SC.W, AMO*.W) against the data-memory port shared with normal loads and stores.
- Stalls the pipeline while it issues a read, computes the new value and issues a write.
- Owns the single LR/SC reservation register.
- Sits beside the memory stage. The pipeline holds the AMO instruction in place until done_o.

Parameters:
- RES_GRANULE_LSB, 2, lowest address bit compared for reservation match (word granule).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- amoValid_i  in  1  AMO/LR/SC instruction present; held until done_o
- amoFunct5_i  in  5  instr[31:27]
- amoAddr_i  in  32  effective address (rs1)
- amoRs2_i  in  32  rs2 operand
- flush_i  in  1  trap/redirect; abort uncommitted sequence
- snoopWr_i  in  1  another store wrote data memory this cycle
- snoopAddr_i  in  32  address of that store
- stall_o  out  1  hold pipeline
- done_o  out  1  one-cycle pulse; result_o valid
- misaligned_o  out  1  one-cycle pulse with done_o; addr[1:0]!=0
- result_o  out  32  rd writeback value
- memRStrobe_o  out  1  read request; data returned on memRData_i next cycle
- memAddr_o  out  32  word address for read and write
- memRData_i  in  32  read data
- memWData_o  out  32  write data
- memWMask_o  out  4  byte write enables (1111 or 0000)

Behaviour:
- Reset (reset_i low, async):
  - state=IDLE, resValid=0, resAddr=0.
  - All outputs 0.
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE, amoValid_i=1, flush_i=0:
  - Capture funct5/addr/rs2.
  - stall_o=1 combinationally.
- Next state from IDLE:
  - addr[1:0]!=0 → DONE, misaligned=1, no memory access, reservation cleared.
  - SC.W (00011), resValid && resAddr==addr[31:2] → WRITE, result=0.
  - SC.W, otherwise → DONE, result=1, no write.
  - SC always clears resValid when it leaves IDLE.
  - Else → READ.
- READ: memRStrobe_o=1, memAddr_o=captured addr. → CALC.
- CALC:
  - Latch old=memRData_i; result=old.
  - LR.W (00010): set resValid=1, resAddr=addr[31:2]; → DONE.
  - Otherwise compute new → WRITE. Operations:
    - SWAP 00001: rs2
    - ADD 00000: old+rs2 (mod 2^32)
    - XOR 00100
    - AND 01100
    - OR 01000
    - MIN 10000 / MAX 10100: signed compare
    - MINU 11000 / MAXU 11100: unsigned compare
  - Any other funct5 → DONE, no write, result=old.
- WRITE:
  - memWMask_o=1111, memWData_o=new (SC: rs2), memAddr_o=addr. → DONE.
  - Any write whose word matches resAddr clears resValid.
- DONE:
  - done_o=1, stall_o=0, misaligned_o as captured. → IDLE.
  - The pipeline advances on this edge. amoValid_i seen in the following IDLE belongs to the next instruction.
- stall_o = (IDLE & amoValid_i & !flush_i) | READ | CALC | WRITE.
- Latency from first IDLE cycle through done_o (inclusive):
  - AMO: 5 cycles
  - LR: 4 cycles
  - SC success: 3 cycles
  - SC fail / misaligned: 2 cycles
- memWMask_o=0000 and memRStrobe_o=0 outside WRITE and READ respectively.
- Snoop: snoopWr_i && snoopAddr_i[31:2]==resAddr clears resValid.
  - LR set in the same cycle takes priority (reservation valid afterwards).
- flush_i:
  - In IDLE/READ/CALC: → IDLE next cycle, no write, no done_o, resValid cleared.
  - In WRITE/DONE: ignored; the write is committed and DONE completes.
- Reset mid-operation: immediate IDLE. A write in flight is dropped: mask forced 0 asynchronously.

Test Plan:
- AMOADD.W, mem[0x100]=5, rs2=3 → memRStrobe_o at cycle1 with addr 0x100; write 8/mask 1111 at cycle3; done_o at cycle4, result_o=5; stall_o high cycles 0-3.
- AMOMAX.W vs AMOMAXU.W, mem=0xFFFFFFFF, rs2=1 → MAX writes 1; MAXU writes 0xFFFFFFFF; both result 0xFFFFFFFF.
- LR.W 0x200 (mem=0x11), then SC.W 0x200 rs2=0xAB → LR result 0x11 at cycle3; SC writes 0xAB at 0x200, result 0; resValid=0 afterwards; second SC returns 1 with no write.
- LR.W 0x200, snoopWr_i at 0x202, then SC.W 0x200 → SC result 1, memWMask_o stays 0000; snoop to 0x204 instead → SC succeeds.
- AMOSWAP with flush_i in CALC → no write, no done_o, IDLE next cycle; same flush in WRITE → write occurs, done_o pulses.
- AMOOR at 0x102 → done_o+misaligned_o at cycle1, no strobe/write; reset_i low during WRITE → mask 0000 immediately, state IDLE, resValid 0.
